// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word frames, blocking fill from memory control.
// Hits are combinational in IDLE; a miss parks the FSM in FILL until iwait drops.
module icache (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state, next_state;
    logic [15:0] valid;
    logic [25:0] tags [16];
    logic [31:0] data [16];
    logic [31:0] miss_addr;

    logic [25:0] req_tag;
    logic [3:0]  req_idx;
    logic [25:0] miss_tag;
    logic [3:0]  miss_idx;
    logic        latch_miss;
    logic        fill_en;

    assign req_tag  = imemaddr[31:6];
    assign req_idx  = imemaddr[5:2];
    assign miss_tag = miss_addr[31:6];
    assign miss_idx = miss_addr[5:2];

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        latch_miss = 1'b0;
        fill_en    = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (valid[req_idx] && (tags[req_idx] == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = data[req_idx];
                    end else begin
                        latch_miss = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                // Fill data is written on this edge but never forwarded to imemload.
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill_en    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= 32'h0;
        end else begin
            state <= next_state;
            if (latch_miss)
                miss_addr <= {imemaddr[31:2], 2'b00};
        end
    end

    // Frames are never dirty, so a conflicting fill simply overwrites.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 16'h0;
            for (int i = 0; i < 16; i++) begin
                tags[i] <= 26'h0;
                data[i] <= 32'h0;
            end
        end else if (fill_en) begin
            valid[miss_idx] <= 1'b1;
            tags[miss_idx]  <= miss_tag;
            data[miss_idx]  <= iload;
        end
    end

endmodule
